// File: rtl/exu_alu_cmt_buf.sv
// ALU-to-commit buffer: a small in-order FIFO between the ALU result stage and
// the commit stage. Stalls intake behind an ebreak until it commits, and
// freezes (discarding all entries) once commit reports a trap.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   alu_o_*              ALU result handshake + payload (enqueue side)
//   cmt_o_*              head entry handshake + payload (dequeue side)
//   commit_trap          commit raised a trap; buffer halts until reset
//   buf_count            occupied entries
//   buf_halted           buffer frozen after a trap
//   retire_cnt           running count of commit handshakes (wraps)

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package exu_alu_cmt_buf_pkg;

  localparam int unsigned PC_W    = `PC_SIZE;
  localparam int unsigned INSTR_W = `INSTR_SIZE;
  localparam int unsigned XLEN_W  = `XLEN;

  // One buffered ALU result
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pc_vld;
    logic [XLEN_W-1:0]  imm;
    logic               ebreak;
  } cmt_entry_t;

endpackage

module exu_alu_cmt_buf
  import exu_alu_cmt_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_o_valid,
  output logic                       alu_o_ready,
  input  logic [PC_W-1:0]            alu_o_pc,
  input  logic [INSTR_W-1:0]         alu_o_instr,
  input  logic                       alu_o_pc_vld,
  input  logic [XLEN_W-1:0]          alu_o_imm,
  input  logic                       alu_o_ebreak,
  output logic                       cmt_o_valid,
  input  logic                       cmt_o_ready,
  output logic [PC_W-1:0]            cmt_o_pc,
  output logic [INSTR_W-1:0]         cmt_o_instr,
  output logic                       cmt_o_pc_vld,
  output logic [XLEN_W-1:0]          cmt_o_imm,
  output logic                       cmt_o_ebreak,
  input  logic                       commit_trap,
  output logic [$clog2(DEPTH):0]     buf_count,
  output logic                       buf_halted,
  output logic [63:0]                retire_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  cmt_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fence_q;
  logic [63:0]      retire_q;

  logic             full, halted, enq, deq, trap_now;
  cmt_entry_t       head, wr_entry;

  // Handshake qualifiers, all derived from registered state only
  assign halted      = (state_q == ST_HALT);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign alu_o_ready = !full && !halted && !fence_q;
  assign cmt_o_valid = (count_q != '0) && !halted;
  assign enq         = alu_o_valid && alu_o_ready;
  assign deq         = cmt_o_valid && cmt_o_ready;

  assign wr_entry = '{pc:     alu_o_pc,
                      instr:  alu_o_instr,
                      pc_vld: alu_o_pc_vld,
                      imm:    alu_o_imm,
                      ebreak: alu_o_ebreak};

  assign head = mem_q[rd_ptr_q];

  // Head payload is forced to zero whenever nothing is offered
  assign cmt_o_pc     = cmt_o_valid ? head.pc     : '0;
  assign cmt_o_instr  = cmt_o_valid ? head.instr  : '0;
  assign cmt_o_pc_vld = cmt_o_valid ? head.pc_vld : 1'b0;
  assign cmt_o_imm    = cmt_o_valid ? head.imm    : '0;
  assign cmt_o_ebreak = cmt_o_valid ? head.ebreak : 1'b0;

  assign buf_count  = count_q;
  assign buf_halted = halted;
  assign retire_cnt = retire_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a trap in RUN halts; HALT is only left through reset
  always_comb begin
    state_d  = state_q;
    trap_now = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (commit_trap) begin
          state_d  = ST_HALT;
          trap_now = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // Entry storage; stale contents are harmless since count gates visibility
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointers, occupancy, fence and retire counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fence_q  <= 1'b0;
      retire_q <= '0;
    end else begin
      // A handshake on the halting edge still retires
      if (deq) begin
        retire_q <= retire_q + 64'd1;
      end
      if (trap_now) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        fence_q  <= 1'b0;
      end else begin
        if (enq) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
        // Fence only admits one ebreak, so the ebreak entry is the youngest
        if (enq && alu_o_ebreak) begin
          fence_q <= 1'b1;
        end else if (deq && head.ebreak) begin
          fence_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_alu_cmt_buf.sv
// Directed bench for exu_alu_cmt_buf: ordering, full/empty corners, ebreak
// fence, trap halt, retire counter wrap and reset priority over a trap.

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_exu_alu_cmt_buf;

  localparam int unsigned DEPTH = 2;

  logic                   clk;
  logic                   rst;
  logic                   alu_o_valid;
  logic                   alu_o_ready;
  logic [`PC_SIZE-1:0]    alu_o_pc;
  logic [`INSTR_SIZE-1:0] alu_o_instr;
  logic                   alu_o_pc_vld;
  logic [`XLEN-1:0]       alu_o_imm;
  logic                   alu_o_ebreak;
  logic                   cmt_o_valid;
  logic                   cmt_o_ready;
  logic [`PC_SIZE-1:0]    cmt_o_pc;
  logic [`INSTR_SIZE-1:0] cmt_o_instr;
  logic                   cmt_o_pc_vld;
  logic [`XLEN-1:0]       cmt_o_imm;
  logic                   cmt_o_ebreak;
  logic                   commit_trap;
  logic [$clog2(DEPTH):0] buf_count;
  logic                   buf_halted;
  logic [63:0]            retire_cnt;

  int unsigned n_vec;
  int unsigned n_miss;

  exu_alu_cmt_buf #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_o_valid  (alu_o_valid),
    .alu_o_ready  (alu_o_ready),
    .alu_o_pc     (alu_o_pc),
    .alu_o_instr  (alu_o_instr),
    .alu_o_pc_vld (alu_o_pc_vld),
    .alu_o_imm    (alu_o_imm),
    .alu_o_ebreak (alu_o_ebreak),
    .cmt_o_valid  (cmt_o_valid),
    .cmt_o_ready  (cmt_o_ready),
    .cmt_o_pc     (cmt_o_pc),
    .cmt_o_instr  (cmt_o_instr),
    .cmt_o_pc_vld (cmt_o_pc_vld),
    .cmt_o_imm    (cmt_o_imm),
    .cmt_o_ebreak (cmt_o_ebreak),
    .commit_trap  (commit_trap),
    .buf_count    (buf_count),
    .buf_halted   (buf_halted),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                           input logic eb);
    alu_o_valid  = v;
    alu_o_pc     = `PC_SIZE'(pc);
    alu_o_instr  = `INSTR_SIZE'(eb ? 32'h0010_0073 : 32'h0000_0013);
    alu_o_pc_vld = v;
    alu_o_imm    = `XLEN'(imm);
    alu_o_ebreak = eb;
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    rst          = 1'b0;
    cmt_o_ready  = 1'b0;
    commit_trap  = 1'b0;
    drive_alu(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset
    tick();
    tick();
    chk("rst_count",   64'(buf_count),   64'd0);
    chk("rst_halted",  64'(buf_halted),  64'd0);
    chk("rst_retire",  retire_cnt,       64'd0);
    chk("rst_cvalid",  64'(cmt_o_valid), 64'd0);
    chk("rst_cpc",     64'(cmt_o_pc),    64'd0);
    chk("rst_aready",  64'(alu_o_ready), 64'd1);
    rst = 1'b1;

    // Fill with two entries while commit stalls
    drive_alu(1'b1, 32'h8000_0000, 32'd5, 1'b0);
    tick();
    chk("p1_count",  64'(buf_count),    64'd1);
    chk("p1_cvalid", 64'(cmt_o_valid),  64'd1);
    chk("p1_cpc",    64'(cmt_o_pc),     64'h8000_0000);
    chk("p1_cimm",   64'(cmt_o_imm),    64'd5);
    chk("p1_cinstr", 64'(cmt_o_instr),  64'h13);
    chk("p1_cpcvld", 64'(cmt_o_pc_vld), 64'd1);
    drive_alu(1'b1, 32'h8000_0004, 32'd6, 1'b0);
    tick();
    chk("p2_count",  64'(buf_count),   64'd2);
    chk("p2_aready", 64'(alu_o_ready), 64'd0);
    chk("p2_cpc",    64'(cmt_o_pc),    64'h8000_0000);

    // Full with valid and ready together: drain one, enqueue nothing
    drive_alu(1'b1, 32'h8000_0008, 32'd7, 1'b0);
    cmt_o_ready = 1'b1;
    tick();
    chk("full_count",  64'(buf_count), 64'd1);
    chk("full_retire", retire_cnt,     64'd1);
    chk("full_cpc",    64'(cmt_o_pc),  64'h8000_0004);
    chk("full_cimm",   64'(cmt_o_imm), 64'd6);
    drive_alu(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("drain_count",  64'(buf_count),   64'd0);
    chk("drain_retire", retire_cnt,       64'd2);
    chk("drain_cvalid", 64'(cmt_o_valid), 64'd0);
    chk("drain_cpc",    64'(cmt_o_pc),    64'd0);

    // Empty with valid and ready together: enqueue only
    drive_alu(1'b1, 32'h8000_000C, 32'd8, 1'b0);
    tick();
    chk("empty_count",  64'(buf_count), 64'd1);
    chk("empty_retire", retire_cnt,     64'd2);
    chk("empty_cpc",    64'(cmt_o_pc),  64'h8000_000C);

    // Simultaneous enq/deq, enqueued entry is an ebreak
    drive_alu(1'b1, 32'h8000_0010, 32'd9, 1'b1);
    tick();
    chk("eb_count",  64'(buf_count),    64'd1);
    chk("eb_retire", retire_cnt,        64'd3);
    chk("eb_cpc",    64'(cmt_o_pc),     64'h8000_0010);
    chk("eb_cebrk",  64'(cmt_o_ebreak), 64'd1);
    chk("eb_aready", 64'(alu_o_ready),  64'd0);

    // Another valid waits behind the fence
    drive_alu(1'b1, 32'h8000_0014, 32'd10, 1'b0);
    cmt_o_ready = 1'b0;
    tick();
    chk("fence1_count",  64'(buf_count),   64'd1);
    chk("fence1_aready", 64'(alu_o_ready), 64'd0);
    tick();
    chk("fence2_aready", 64'(alu_o_ready), 64'd0);
    chk("fence2_cpc",    64'(cmt_o_pc),    64'h8000_0010);
    cmt_o_ready = 1'b1;
    tick();
    chk("unfence_count",  64'(buf_count),   64'd0);
    chk("unfence_aready", 64'(alu_o_ready), 64'd1);
    chk("unfence_retire", retire_cnt,       64'd4);
    cmt_o_ready = 1'b0;
    tick();
    chk("after_count", 64'(buf_count), 64'd1);
    chk("after_cpc",   64'(cmt_o_pc),  64'h8000_0014);
    chk("after_cebrk", 64'(cmt_o_ebreak), 64'd0);

    // Trap with two entries, plus a same-edge dequeue
    drive_alu(1'b1, 32'h8000_0018, 32'd11, 1'b0);
    tick();
    chk("pretrap_count", 64'(buf_count), 64'd2);
    commit_trap = 1'b1;
    cmt_o_ready = 1'b1;
    tick();
    chk("trap_count",  64'(buf_count),   64'd0);
    chk("trap_halted", 64'(buf_halted),  64'd1);
    chk("trap_cvalid", 64'(cmt_o_valid), 64'd0);
    chk("trap_aready", 64'(alu_o_ready), 64'd0);
    chk("trap_retire", retire_cnt,       64'd5);
    chk("trap_cpc",    64'(cmt_o_pc),    64'd0);
    commit_trap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_halted", 64'(buf_halted),  64'd1);
      chk("halt_count",  64'(buf_count),   64'd0);
      chk("halt_aready", 64'(alu_o_ready), 64'd0);
      chk("halt_retire", retire_cnt,       64'd5);
    end

    // Reset leaves HALT
    rst = 1'b0;
    drive_alu(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("rst2_halted", 64'(buf_halted),  64'd0);
    chk("rst2_count",  64'(buf_count),   64'd0);
    chk("rst2_retire", retire_cnt,       64'd0);
    chk("rst2_aready", 64'(alu_o_ready), 64'd1);
    rst = 1'b1;

    // Retire counter wrap
    cmt_o_ready = 1'b0;
    drive_alu(1'b1, 32'h8000_0020, 32'd12, 1'b0);
    tick();
    drive_alu(1'b0, 32'h0, 32'h0, 1'b0);
    dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("wrap_pre", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    cmt_o_ready = 1'b1;
    tick();
    chk("wrap_retire", retire_cnt,     64'd0);
    chk("wrap_count",  64'(buf_count), 64'd0);

    // Reset wins over a same-edge trap and handshake
    cmt_o_ready = 1'b0;
    drive_alu(1'b1, 32'h8000_0024, 32'd13, 1'b0);
    tick();
    chk("rt_pre_count", 64'(buf_count), 64'd1);
    drive_alu(1'b0, 32'h0, 32'h0, 1'b0);
    rst         = 1'b0;
    commit_trap = 1'b1;
    cmt_o_ready = 1'b1;
    tick();
    chk("rt_count",  64'(buf_count),   64'd0);
    chk("rt_halted", 64'(buf_halted),  64'd0);
    chk("rt_retire", retire_cnt,       64'd0);
    chk("rt_cvalid", 64'(cmt_o_valid), 64'd0);
    rst         = 1'b1;
    commit_trap = 1'b0;
    tick();
    chk("rt_post_halted", 64'(buf_halted),  64'd0);
    chk("rt_post_aready", 64'(alu_o_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
